// File: rtl/matmul_result_drain.sv
// Ping-pong result buffer behind the matmul array: captures whole D matrices and drains them one row per beat.
// Optional MATMUL_DRAIN_SAT_EN: shift-and-saturate each element to OUT_W bits on the read path.
module matmul_result_drain #(
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0,
    localparam int RW   = (M > 1) ? $clog2(M) : 1,
`ifdef MATMUL_DRAIN_SAT_EN
    localparam int EW   = OUT_W
`else
    localparam int EW   = ACC_W
`endif
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic signed [M-1:0][N-1:0][ACC_W-1:0]  D_i,
    input  logic                                   valid_in,
    output logic                                   ready_in,
    output logic [N*EW-1:0]                        row_o,
    output logic [RW-1:0]                          row_idx_o,
    output logic                                   last_o,
    output logic                                   valid_out,
    input  logic                                   ready_out,
    output logic [1:0]                             occ_o
);

    logic [M-1:0][N-1:0][ACC_W-1:0] slot_reg [2];
    logic [1:0]    occ_reg;
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [RW-1:0] row_reg;

    logic push;
    logic beat;
    logic row_is_last;
    logic pop_last;

    // ready_in depends only on registered occupancy, so a same-cycle pop never frees the slot early.
    assign ready_in    = !rst_i && (occ_reg != 2'd2);
    assign valid_out   = (occ_reg != 2'd0);
    assign push        = valid_in && ready_in;
    assign beat        = valid_out && ready_out;
    assign row_is_last = (row_reg == RW'(M - 1));
    assign pop_last    = beat && row_is_last;

    assign row_idx_o = row_reg;
    assign last_o    = valid_out && row_is_last;
    assign occ_o     = occ_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            logic signed [ACC_W-1:0] elem;
            logic        [EW-1:0]    elem_out;

            assign elem = $signed(slot_reg[rd_ptr_reg][row_reg][gi]);
`ifdef MATMUL_DRAIN_SAT_EN
            localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
            localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
            logic signed [ACC_W-1:0] shifted;

            assign shifted  = elem >>> SHIFT;
            assign elem_out = (shifted > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                              (shifted < SAT_MIN) ? SAT_MIN[OUT_W-1:0] :
                                                    shifted[OUT_W-1:0];
`else
            assign elem_out = elem;
`endif
            // Empty buffer presents zeros rather than stale slot contents.
            assign row_o[(gi+1)*EW-1 -: EW] = valid_out ? elem_out : '0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (push) begin
            slot_reg[wr_ptr_reg] <= D_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_reg    <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            row_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (beat) begin
                if (row_is_last) begin
                    row_reg    <= '0;
                    rd_ptr_reg <= ~rd_ptr_reg;
                end else begin
                    row_reg <= row_reg + RW'(1);
                end
            end
            case ({push, pop_last})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain (M=N=2, ACC_W=32); covers MATMUL_DRAIN_SAT_EN when defined.
module tb_matmul_result_drain;

`ifdef MATMUL_DRAIN_SAT_EN
    localparam int EW = 8;
`else
    localparam int EW = 32;
`endif

    logic                           clk_i = 1'b0;
    logic                           rst_i;
    logic signed [1:0][1:0][31:0]   D_i;
    logic                           valid_in;
    logic                           ready_in;
    logic [2*EW-1:0]                row_o;
    logic [0:0]                     row_idx_o;
    logic                           last_o;
    logic                           valid_out;
    logic                           ready_out;
    logic [1:0]                     occ_o;

    int vectors = 0;
    int miscompares = 0;

    matmul_result_drain #(
        .M(2), .N(2), .ACC_W(32)
`ifdef MATMUL_DRAIN_SAT_EN
        , .OUT_W(8), .SHIFT(2)
`endif
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .D_i(D_i), .valid_in(valid_in),
        .ready_in(ready_in), .row_o(row_o), .row_idx_o(row_idx_o),
        .last_o(last_o), .valid_out(valid_out), .ready_out(ready_out),
        .occ_o(occ_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic signed [1:0][1:0][31:0] mat(input int a, input int b, input int c, input int d);
        logic signed [1:0][1:0][31:0] m;
        m[0][0] = a; m[0][1] = b; m[1][0] = c; m[1][1] = d;
        return m;
    endfunction

    function automatic logic [63:0] row(input int e0, input int e1);
        logic [31:0] lo, hi;
        lo = e0; hi = e1;
        return {hi, lo};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {valid_out, last_o, row_idx_o, occ_o} packed for compact checks
    function automatic logic [63:0] st();
        return {59'd0, valid_out, last_o, row_idx_o, occ_o};
    endfunction

    function automatic logic [63:0] mk(input bit v, input bit l, input bit idx, input int occ);
        logic [1:0] o;
        o = occ[1:0];
        return {59'd0, v, l, idx, o};
    endfunction

    initial begin
        rst_i = 1'b1; valid_in = 1'b0; ready_out = 1'b0; D_i = '0;
        tick(); tick();
        chk("reset_ready_in", {63'd0, ready_in}, 64'd0);
        chk("reset_state", st(), mk(0, 0, 0, 0));
        chk("reset_row", {{(64-2*EW){1'b0}}, row_o}, 64'd0);
        rst_i = 1'b0; #1;
        chk("post_reset_ready_in", {63'd0, ready_in}, 64'd1);

`ifndef MATMUL_DRAIN_SAT_EN
        // single matrix
        D_i = mat(1, 2, 3, 4); valid_in = 1'b1; ready_out = 1'b1;
        tick(); valid_in = 1'b0;
        chk("single_row0", row_o, row(1, 2));
        chk("single_st0", st(), mk(1, 0, 0, 1));
        tick();
        chk("single_row1", row_o, row(3, 4));
        chk("single_st1", st(), mk(1, 1, 1, 1));
        tick();
        chk("single_empty", st(), mk(0, 0, 0, 0));
        $display("txn single matrix done");

        // fill and backpressure
        ready_out = 1'b0;
        D_i = mat(5, 6, 7, 8); valid_in = 1'b1; tick();
        D_i = mat(9, 10, 11, 12); tick();
        chk("full_occ", st(), mk(1, 0, 0, 2));
        chk("full_ready_in", {63'd0, ready_in}, 64'd0);
        D_i = mat(99, 98, 97, 96); tick(); valid_in = 1'b0;
        chk("third_blocked", st(), mk(1, 0, 0, 2));
        chk("bp_row0", row_o, row(5, 6));
        ready_out = 1'b1; tick();
        chk("bp_row1", row_o, row(7, 8));
        chk("bp_st1", st(), mk(1, 1, 1, 2));
        chk("bp_ready_hold", {63'd0, ready_in}, 64'd0);
        tick();
        chk("bp_ready_rise", {63'd0, ready_in}, 64'd1);
        chk("bp_row2", row_o, row(9, 10));
        chk("bp_st2", st(), mk(1, 0, 0, 1));
        tick();
        chk("bp_row3", row_o, row(11, 12));
        chk("bp_st3", st(), mk(1, 1, 1, 1));
        tick();
        chk("bp_empty", st(), mk(0, 0, 0, 0));
        $display("txn fill/backpressure done");

        // stall on the last row
        D_i = mat(21, 22, 23, 24); valid_in = 1'b1; tick(); valid_in = 1'b0;
        tick(); ready_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_row", row_o, row(23, 24));
            chk("stall_st", st(), mk(1, 1, 1, 1));
            tick();
        end
        ready_out = 1'b1; tick();
        chk("stall_release", st(), mk(0, 0, 0, 0));
        $display("txn stall done");

        // push coinciding with final pop
        D_i = mat(31, 32, 33, 34); valid_in = 1'b1; tick(); valid_in = 1'b0;
        tick();
        chk("sim_pre", st(), mk(1, 1, 1, 1));
        D_i = mat(41, 42, 43, 44); valid_in = 1'b1; tick(); valid_in = 1'b0;
        chk("sim_occ", st(), mk(1, 0, 0, 1));
        chk("sim_row0", row_o, row(41, 42));
        tick();
        chk("sim_row1", row_o, row(43, 44));
        tick();
        chk("sim_empty", st(), mk(0, 0, 0, 0));
        $display("txn simultaneous push/pop done");

        // reset in the middle of a two-matrix backlog
        ready_out = 1'b0;
        D_i = mat(51, 52, 53, 54); valid_in = 1'b1; tick();
        D_i = mat(61, 62, 63, 64); tick(); valid_in = 1'b0;
        ready_out = 1'b1; tick();
        chk("rst_pre", st(), mk(1, 1, 1, 2));
        rst_i = 1'b1; tick();
        chk("rst_mid_st", st(), mk(0, 0, 0, 0));
        chk("rst_mid_ready", {63'd0, ready_in}, 64'd0);
        rst_i = 1'b0; #1;
        chk("rst_after_ready", {63'd0, ready_in}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_stale", st(), mk(0, 0, 0, 0));
        end
        $display("txn reset mid-drain done");
`else
        // saturation: 1000>>>2=250 -> 127, -1000>>>2=-250 -> -128, 12>>>2=3, -13>>>2=-4
        D_i = mat(1000, -1000, 12, -13); valid_in = 1'b1; ready_out = 1'b1;
        tick(); valid_in = 1'b0;
        chk("sat_row0", {48'd0, row_o}, 64'h807f);
        chk("sat_st0", st(), mk(1, 0, 0, 1));
        tick();
        chk("sat_row1", {48'd0, row_o}, 64'hfc03);
        chk("sat_st1", st(), mk(1, 1, 1, 1));
        tick();
        chk("sat_empty", st(), mk(0, 0, 0, 0));
        $display("txn saturation done");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
